// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, digit select
// fields and the 3-bit window recoder.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic single;
        logic dbl;
        logic neg;
    } booth_sel_t;

    // Standard radix-4 recoding: 000/111 -> 0, 001/010 -> +1, 011 -> +2,
    // 100 -> -2, 101/110 -> -1.
    function automatic booth_sel_t booth_decode(input logic [2:0] window);
        booth_sel_t sel;
        sel.single = window[1] ^ window[0];
        sel.dbl    = (window == 3'b011) || (window == 3'b100);
        sel.neg    = window[2] && !(window[1] && window[0]);
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: one recoded digit times the
// (WIDTH+1)-bit extended multiplicand, producing a WIDTH+2-bit signed result.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        [2:0]       window,
    input  logic signed [WIDTH:0]   mcand,
    output logic signed [WIDTH+1:0] pp
);

    booth_sel_t              sel;
    logic signed [WIDTH+1:0] mag;

    // The extended multiplicand spans [-2^(WIDTH-1), 2^WIDTH-1], so even
    // -2 x mcand stays representable in WIDTH+2 bits.
    always_comb begin
        sel = booth_decode(window);
        mag = '0;
        if (sel.single)
            mag = {mcand[WIDTH], mcand};
        else if (sel.dbl)
            mag = {mcand, 1'b0};
        pp = sel.neg ? -mag : mag;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned.
// Optional BOOTH_EARLY_TERM_EN ends RUN once the remaining multiplier digits are all zero.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int K  = WIDTH / 2 + 1;
    localparam int CW = $clog2(K);
    localparam int SW = WIDTH + 3;

    state_t                  state;
    logic [CW-1:0]           digit_cnt;
    logic [SW-1:0]           mplr_sr;
    logic [WIDTH:0]          mcand;
    logic [2*WIDTH-1:0]      acc;

    logic signed [WIDTH+1:0] pp;
    logic [2*WIDTH-1:0]      pp_ext;
    logic [2*WIDTH-1:0]      pp_shifted;
    logic [2*WIDTH-1:0]      acc_next;
    logic [SW-1:0]           mplr_next;
    logic                    last_digit;

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .window (mplr_sr[2:0]),
        .mcand  (mcand),
        .pp     (pp)
    );

    // The multiplier shift register holds the unscanned extended bits with the
    // overlap bit at position 0; its arithmetic shift keeps the fill consistent.
    always_comb begin
        pp_ext     = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
        pp_shifted = pp_ext << {digit_cnt, 1'b0};
        acc_next   = acc + pp_shifted;
        mplr_next  = {{2{mplr_sr[SW-1]}}, mplr_sr[SW-1:2]};
        last_digit = (digit_cnt == CW'(K - 1));
`ifdef BOOTH_EARLY_TERM_EN
        if ((&mplr_next) || !(|mplr_next))
            last_digit = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            digit_cnt <= '0;
            mplr_sr   <= '0;
            mcand     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand     <= {is_signed & a[WIDTH-1], a};
                        mplr_sr   <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
                        acc       <= '0;
                        digit_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    mplr_sr   <= mplr_next;
                    digit_cnt <= digit_cnt + 1'b1;
                    if (last_digit) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
